// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared APU constants: envelope channel count, ROM bus widths, channel indices.
package apu_pkg;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 16;

  localparam int PULSE1 = 0;
  localparam int PULSE2 = 1;
  localparam int NOISE  = 2;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: eligible mask and start pointer to one-hot winner.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_elig,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_win,
  output logic          o_valid
);

  // Offset i is tried before offset i+1, so the first eligible channel at or after ptr wins.
  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!o_valid && i_elig[k] &&
            (((int'(i_ptr) + i) - (((int'(i_ptr) + i) >= N) ? N : 0)) == k)) begin
          o_win[k] = 1'b1;
          o_valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/envelope_rom_arbiter.sv
// rtl/envelope_rom_arbiter.sv - round-robin arbiter sharing one synchronous envelope ROM between channels.
module envelope_rom_arbiter
  import apu_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_addr,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic [NUM_REQ-1:0]          o_rvalid,
  output logic [DATA_W-1:0]           o_rdata,
  output logic [ADDR_W-1:0]           o_rom_addr,
  input  logic [DATA_W-1:0]           i_rom_data
);

  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_rvalid;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [PW-1:0]      r_ptr;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_win;
  logic               w_valid;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [PW-1:0]      w_next_ptr;

  // A channel being granted this cycle is still holding i_req; masking it avoids a double read.
  assign w_elig = i_req & ~r_gnt;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  always_comb begin
    w_win_addr = r_rom_addr;
    w_next_ptr = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win[k]) begin
        w_win_addr = i_addr[k*ADDR_W +: ADDR_W];
        w_next_ptr = (k == NUM_REQ - 1) ? '0 : PW'(k + 1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_rom_addr <= '0;
      r_ptr      <= '0;
    end else begin
      r_rvalid <= r_gnt;
      r_gnt    <= w_valid ? w_win : '0;
      if (w_valid) begin
        r_rom_addr <= w_win_addr;
        r_ptr      <= w_next_ptr;
      end
    end
  end

  assign o_gnt      = r_gnt;
  assign o_rvalid   = r_rvalid;
  assign o_rom_addr = r_rom_addr;
  assign o_rdata    = i_rom_data;

endmodule

// File: tb/tb_envelope_rom_arbiter.sv
// tb/tb_envelope_rom_arbiter.sv - scoreboard bench: directed request patterns, cycle-stamped grant/rvalid checks.
module tb_envelope_rom_arbiter;
  import apu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [2:0]  i_req = '0;
  logic [23:0] i_addr = '0;
  logic [2:0]  o_gnt;
  logic [2:0]  o_rvalid;
  logic [15:0] o_rdata;
  logic [7:0]  o_rom_addr;
  logic [15:0] i_rom_data = '0;

  envelope_rom_arbiter dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .o_gnt      (o_gnt),
    .o_rvalid   (o_rvalid),
    .o_rdata    (o_rdata),
    .o_rom_addr (o_rom_addr),
    .i_rom_data (i_rom_data)
  );

  always #5 i_clk = ~i_clk;

  logic [15:0] rom [256];
  always @(posedge i_clk) i_rom_data <= rom[o_rom_addr];

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  oh;
    logic [15:0] val;
    int          at;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  function automatic logic [7:0] addr_of(input int ch);
    logic [7:0] base;
    base = 8'h10;
    return base + 8'(ch);
  endfunction

  function automatic logic [15:0] data_of(input int ch);
    logic [15:0] d;
    case (ch)
      0:       d = 16'hBEEF;
      1:       d = 16'hCAFE;
      default: d = 16'hF00D;
    endcase
    return d;
  endfunction

  task automatic exp_g_only(input int ch, input int at);
    exp_t e;
    e.oh = 3'(1 << ch); e.val = {8'h00, addr_of(ch)}; e.at = at;
    gq.push_back(e);
  endtask

  task automatic exp_g(input int ch, input int at);
    exp_t e;
    exp_g_only(ch, at);
    e.oh = 3'(1 << ch); e.val = data_of(ch); e.at = at + 1;
    rq.push_back(e);
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (o_gnt != 3'b000) begin
      if (gq.size() == 0) chk("gnt_unexpected", {29'd0, o_gnt}, 32'd0);
      else begin
        e = gq.pop_front();
        chk("gnt_onehot", {29'd0, o_gnt}, {29'd0, e.oh});
        chk("gnt_rom_addr", {24'd0, o_rom_addr}, {16'd0, e.val});
        chk("gnt_cycle", cyc, e.at);
      end
    end
    if (o_rvalid != 3'b000) begin
      if (rq.size() == 0) chk("rvalid_unexpected", {29'd0, o_rvalid}, 32'd0);
      else begin
        e = rq.pop_front();
        chk("rvalid_onehot", {29'd0, o_rvalid}, {29'd0, e.oh});
        chk("rvalid_rdata", {16'd0, o_rdata}, {16'd0, e.val});
        chk("rvalid_cycle", cyc, e.at);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_addr(input int ch, input logic [7:0] a);
    i_addr[ch*8 +: 8] = a;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = {8'(a), ~8'(a)};
    rom[8'h10] = 16'hBEEF;
    rom[8'h11] = 16'hCAFE;
    rom[8'h12] = 16'hF00D;
    set_addr(PULSE1, 8'h10);
    set_addr(PULSE2, 8'h11);
    set_addr(NOISE,  8'h12);

    // Reset state
    repeat (3) tick();
    chk("rst_gnt", {29'd0, o_gnt}, 32'd0);
    chk("rst_rvalid", {29'd0, o_rvalid}, 32'd0);
    chk("rst_rom_addr", {24'd0, o_rom_addr}, 32'd0);
    i_rst = 1'b0;
    tick();

    // Single request, dropped on grant
    i_req = 3'b001; exp_g(PULSE1, cyc + 1);
    tick(); i_req = 3'b000;
    repeat (4) tick();

    // All three from reset
    i_rst = 1'b1; tick(); i_rst = 1'b0; tick();
    i_req = 3'b111;
    exp_g(PULSE1, cyc + 1); exp_g(PULSE2, cyc + 2); exp_g(NOISE, cyc + 3);
    tick(); i_req = 3'b110;
    tick(); i_req = 3'b100;
    tick(); i_req = 3'b000;
    repeat (3) tick();

    // Wrap: ch1 win leaves ptr=2, then ch0+ch2 -> ch2 first, then ch0
    i_req = 3'b010; exp_g(PULSE2, cyc + 1);
    tick(); i_req = 3'b000;
    tick();
    i_req = 3'b101; exp_g(NOISE, cyc + 1); exp_g(PULSE1, cyc + 2);
    tick(); i_req = 3'b001;
    tick(); i_req = 3'b000;
    tick();
    // ptr must now be 1
    i_req = 3'b111;
    exp_g(PULSE2, cyc + 1); exp_g(NOISE, cyc + 2); exp_g(PULSE1, cyc + 3);
    tick(); i_req = 3'b101;
    tick(); i_req = 3'b001;
    tick(); i_req = 3'b000;
    repeat (3) tick();

    // ch1 holds 10 cycles alone; idle channels carry junk addresses
    set_addr(PULSE1, 8'h55);
    set_addr(NOISE,  8'hAA);
    i_req = 3'b010;
    for (int i = 0; i < 5; i++) exp_g(PULSE2, cyc + 1 + 2 * i);
    repeat (10) tick();
    i_req = 3'b000;
    repeat (3) tick();
    set_addr(PULSE1, 8'h10);
    set_addr(NOISE,  8'h12);

    // Reset during the grant cycle of ch1 (ptr would otherwise be 2)
    i_req = 3'b010; exp_g_only(PULSE2, cyc + 1);
    tick(); i_req = 3'b000;
    @(negedge i_clk); #1;
    i_rst = 1'b1;
    #1;
    chk("async_rst_gnt", {29'd0, o_gnt}, 32'd0);
    chk("async_rst_rvalid", {29'd0, o_rvalid}, 32'd0);
    chk("async_rst_rom_addr", {24'd0, o_rom_addr}, 32'd0);
    tick(); tick();
    i_rst = 1'b0;
    i_req = 3'b111;
    exp_g(PULSE1, cyc + 1); exp_g(PULSE2, cyc + 2); exp_g(NOISE, cyc + 3);
    tick(); i_req = 3'b110;
    tick(); i_req = 3'b100;
    tick(); i_req = 3'b000;
    repeat (3) tick();

    // Starvation: ch0/ch1 continuous, ch2 joins while ptr=1
    i_req = 3'b011;
    exp_g(PULSE1, cyc + 1); exp_g(PULSE2, cyc + 2); exp_g(PULSE1, cyc + 3);
    tick(); tick(); tick();
    i_req = 3'b111;
    exp_g(PULSE2, cyc + 1); exp_g(NOISE, cyc + 2);
    exp_g(PULSE1, cyc + 3); exp_g(PULSE2, cyc + 4);
    tick(); tick();
    i_req = 3'b011;
    tick(); tick();
    i_req = 3'b000;
    repeat (4) tick();

    chk("gnt_queue_drained", gq.size(), 32'd0);
    chk("rvalid_queue_drained", rq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d: got running expected finished", cyc);
    $fatal(1);
  end

endmodule
